// File: rtl/l1_dcache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | l1_dcache : direct-mapped, write-back, write-allocate L1 data cache       |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
module l1_dcache #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_tag    = 32 - s_offset - s_index
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_byte_enable,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int NUM_SETS = 1 << s_index;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [255:0]        data_arr [NUM_SETS];
  logic [s_tag-1:0]    tag_arr  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_arr;
  logic [NUM_SETS-1:0] dirty_arr;

  logic [s_tag-1:0]   req_tag;
  logic [s_index-1:0] req_index;
  logic [2:0]         req_word;
  logic [255:0]       set_line;
  logic               req_valid;
  logic               hit;
  logic               hit_write;
  logic               wb_done;
  logic               fill_done;
  logic               unused_addr_bits;

  assign req_tag          = mem_address[31 -: s_tag];
  assign req_index        = mem_address[s_offset +: s_index];
  assign req_word         = mem_address[4:2];
  assign unused_addr_bits = ^mem_address[1:0];
  assign set_line         = data_arr[req_index];
  assign req_valid        = mem_read | mem_write;
  assign hit              = valid_arr[req_index] && (tag_arr[req_index] == req_tag);

  // All outputs are forced low while rst is high, even if state is stale.
  always_comb begin
    state_next   = state;
    mem_rdata    = '0;
    mem_resp     = 1'b0;
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    hit_write    = 1'b0;
    wb_done      = 1'b0;
    fill_done    = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (hit) begin
              mem_resp  = 1'b1;
              hit_write = mem_write;
              if (!mem_write) begin
                mem_rdata = set_line[{req_word, 5'b00000} +: 32];
              end
            end else if (dirty_arr[req_index]) begin
              state_next = WRITEBACK;
            end else begin
              state_next = ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          pmem_write   = 1'b1;
          pmem_address = {tag_arr[req_index], req_index, {s_offset{1'b0}}};
          pmem_wdata   = set_line;
          if (pmem_resp) begin
            wb_done    = 1'b1;
            state_next = ALLOCATE;
          end
        end
        ALLOCATE: begin
          pmem_read    = 1'b1;
          pmem_address = {mem_address[31:s_offset], {s_offset{1'b0}}};
          if (pmem_resp) begin
            fill_done  = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid_arr <= '0;
      dirty_arr <= '0;
    end else begin
      state <= state_next;
      if (hit_write) begin
        dirty_arr[req_index] <= 1'b1;
      end
      if (wb_done) begin
        dirty_arr[req_index] <= 1'b0;
      end
      if (fill_done) begin
        valid_arr[req_index] <= 1'b1;
        dirty_arr[req_index] <= 1'b0;
      end
    end
  end

  // Storage carries no reset; contents only matter once the valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_arr[req_index] <= pmem_rdata;
      tag_arr[req_index]  <= req_tag;
    end else if (hit_write) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byte_enable[b]) begin
          data_arr[req_index][{req_word, b[1:0], 3'b000} +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l1_dcache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_l1_dcache : scoreboard bench for l1_dcache with a 3-cycle line memory  |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_l1_dcache;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  l1_dcache dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          issue;
    string       name;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    int          widx;
    logic [31:0] wword;
    string       name;
  } pm_t;

  resp_t        exp_resp[$];
  pm_t          exp_pm[$];
  logic [255:0] mem [logic [31:0]];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every mem_resp must match the oldest outstanding expectation.
  always @(negedge clk) begin
    resp_t e;
    if (mem_resp) begin
      if (exp_resp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got mem_resp=1 rdata %h expected no response", mem_rdata);
      end else begin
        e = exp_resp.pop_front();
        check32({e.name, " rdata"}, mem_rdata, e.rdata);
        check32({e.name, " latency"}, cyc - e.issue, e.lat);
      end
    end
  end

  // Line memory: request seen in cycle k is answered with pmem_resp in cycle k+2.
  initial begin
    int          cnt;
    logic        cur_wr;
    logic [31:0] cur_addr;
    logic [255:0] cur_wdata;
    pm_t         p;
    cnt        = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (cnt == 0) begin
        if (pmem_read || pmem_write) begin
          check32("pmem_exclusive", {31'd0, pmem_read & pmem_write}, 32'd0);
          cur_wr    = pmem_write;
          cur_addr  = pmem_address;
          cur_wdata = pmem_wdata;
          if (exp_pm.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pmem: got wr=%0b addr %h expected no pmem request", cur_wr, cur_addr);
          end else begin
            p = exp_pm.pop_front();
            check32({p.name, " pmem_write"}, {31'd0, cur_wr}, {31'd0, p.wr});
            check32({p.name, " pmem_address"}, cur_addr, p.addr);
            if (p.wr) check32({p.name, " pmem_wdata"}, cur_wdata[p.widx*32 +: 32], p.wword);
          end
          cnt = 1;
        end
      end else if (cnt == 1) begin
        check32("pmem_address_stable", pmem_address, cur_addr);
        cnt = 2;
      end else begin
        check32("pmem_address_stable", pmem_address, cur_addr);
        if (cur_wr) mem[cur_addr] = cur_wdata;
        else pmem_rdata = mem.exists(cur_addr) ? mem[cur_addr] : '0;
        pmem_resp = 1'b1;
        cnt = 0;
      end
    end
  end

  task automatic expect_pm(input string name, input logic wr, input logic [31:0] addr,
                           input int widx, input logic [31:0] wword);
    pm_t p;
    p.name = name; p.wr = wr; p.addr = addr; p.widx = widx; p.wword = wword;
    exp_pm.push_back(p);
  endtask

  task automatic clear_req();
    mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_wdata = '0; mem_byte_enable = '0;
  endtask

  task automatic do_req(input string name, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rd, input int lat);
    resp_t e;
    bit    got;
    @(posedge clk); #1;
    mem_address = addr; mem_read = !wr; mem_write = wr;
    mem_wdata = wdata; mem_byte_enable = be;
    e.rdata = exp_rd; e.lat = lat; e.issue = cyc; e.name = name;
    exp_resp.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (mem_resp) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no mem_resp expected one within 40 cycles", name);
      void'(exp_resp.pop_back());
    end
    @(posedge clk); #1;
    clear_req();
  endtask

  task automatic check_idle_outputs(input string name);
    check32({name, " mem_resp"}, {31'd0, mem_resp}, 32'd0);
    check32({name, " mem_rdata"}, mem_rdata, 32'd0);
    check32({name, " pmem_read"}, {31'd0, pmem_read}, 32'd0);
    check32({name, " pmem_write"}, {31'd0, pmem_write}, 32'd0);
    check32({name, " pmem_address"}, pmem_address, 32'd0);
    check32({name, " pmem_wdata"}, pmem_wdata[31:0] | pmem_wdata[63:32], 32'd0);
  endtask

  initial begin
    bit seen;
    #400000;
    $display("FAIL global_timeout: got no finish expected finish before 400000");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    logic [255:0] line;
    for (int i = 0; i < 8; i++) line[i*32 +: 32] = 32'hA000_0000 + i;
    line[63:32] = 32'hDEAD_BEEF;
    mem[32'h0000_0100] = line;
    for (int i = 0; i < 8; i++) line[i*32 +: 32] = 32'hB000_0000 + i;
    mem[32'h0000_1100] = line;

    // Reset with a request pending: outputs must stay low.
    rst = 1'b1;
    clear_req();
    mem_read = 1'b1; mem_address = 32'h0000_0104;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    clear_req();
    @(negedge clk);
    check_idle_outputs("after_reset");

    expect_pm("cold_read", 1'b0, 32'h0000_0100, 0, 32'h0);
    do_req("cold_read", 1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'hDEAD_BEEF, 4);
    do_req("hit_read", 1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);
    do_req("hit_write", 1'b1, 32'h0000_0104, 32'h1122_3344, 4'b0110, 32'h0, 0);
    do_req("read_after_write", 1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'hDE22_33EF, 0);
    do_req("other_word", 1'b0, 32'h0000_0108, 32'h0, 4'h0, 32'hA000_0002, 0);

    expect_pm("dirty_evict", 1'b1, 32'h0000_0100, 1, 32'hDE22_33EF);
    expect_pm("dirty_fill", 1'b0, 32'h0000_1100, 0, 32'h0);
    do_req("dirty_miss", 1'b0, 32'h0000_1104, 32'h0, 4'h0, 32'hB000_0001, 7);

    expect_pm("clean_fill", 1'b0, 32'h0000_0100, 0, 32'h0);
    do_req("clean_miss", 1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'hDE22_33EF, 4);

    expect_pm("wmiss_fill", 1'b0, 32'h0000_0040, 0, 32'h0);
    do_req("write_miss", 1'b1, 32'h0000_0048, 32'hCAFE_F00D, 4'hF, 32'h0, 4);
    do_req("read_wmiss", 1'b0, 32'h0000_0048, 32'h0, 4'h0, 32'hCAFE_F00D, 0);
    do_req("read_wmiss_nbr", 1'b0, 32'h0000_0044, 32'h0, 4'h0, 32'h0, 0);
    do_req("mask0_write", 1'b1, 32'h0000_004C, 32'hFFFF_FFFF, 4'h0, 32'h0, 0);
    expect_pm("idx2_evict", 1'b1, 32'h0000_0040, 2, 32'hCAFE_F00D);
    expect_pm("idx2_fill", 1'b0, 32'h0000_2040, 0, 32'h0);
    do_req("idx2_dirty_miss", 1'b0, 32'h0000_2048, 32'h0, 4'h0, 32'h0, 7);

    // Reset while the fill is outstanding: request is dropped, no response.
    expect_pm("aborted_fill", 1'b0, 32'h0000_1100, 0, 32'h0);
    @(posedge clk); #1;
    mem_address = 32'h0000_1104; mem_read = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (pmem_read) seen = 1'b1;
    end
    check32("abort pmem_read_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    clear_req();
    @(negedge clk);
    check32("abort pmem_read_in_reset", {31'd0, pmem_read}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check32("abort pmem_read_after", {31'd0, pmem_read}, 32'd0);
    check32("abort pmem_write_after", {31'd0, pmem_write}, 32'd0);
    repeat (4) @(negedge clk);

    expect_pm("post_reset_fill", 1'b0, 32'h0000_1100, 0, 32'h0);
    do_req("post_reset_miss", 1'b0, 32'h0000_1104, 32'h0, 4'h0, 32'hB000_0001, 4);
    expect_pm("post_reset_fill2", 1'b0, 32'h0000_0100, 0, 32'h0);
    do_req("post_reset_miss2", 1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'hDE22_33EF, 4);

    repeat (3) @(negedge clk);
    check32("resp_queue_drained", exp_resp.size(), 32'd0);
    check32("pmem_queue_drained", exp_pm.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l1_dcache.md
Name: l1_dcache

Overview:
Direct-mapped, write-back, write-allocate L1 data cache that sits directly downstream of the pipeline MEM stage. It consumes the datapath's word-granular dcache request (address, read/write, wdata, byte mask) and returns mem_resp/mem_rdata. It fills and evicts 256-bit lines over a single-outstanding physical-memory interface.

Parameters:
s_offset, 5, line offset bits (32-byte line; fixed, 256-bit line)
s_index, 3, set index bits (2**s_index lines)
s_tag, 32-s_offset-s_index, tag width (derived; do not override)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
mem_address  input  32  word-aligned byte address from MEM stage (bits[1:0] ignored)
mem_read  input  1  load request, held until mem_resp
mem_write  input  1  store request, held until mem_resp
mem_wdata  input  32  store data, already lane-shifted
mem_byte_enable  input  4  store byte mask
mem_rdata  output  32  load data word
mem_resp  output  1  one-cycle completion pulse
pmem_address  output  32  line address, bits[4:0]=0
pmem_read  output  1  line fill request
pmem_write  output  1  line writeback request
pmem_wdata  output  256  evicted line
pmem_rdata  input  256  fill line
pmem_resp  input  1  memory completion pulse

Behaviour:
- Address split: tag=addr[31:8], index=addr[7:5], word=addr[4:2] (defaults).
- Storage per set: valid, dirty, tag, 256-bit data. Data/tag arrays are flop-based with asynchronous read. Writes occur at the clk edge.
- Reset (synchronous, rst=1 at posedge): state<=IDLE; all valid and dirty bits<=0. Data and tag contents are don't-care. While in reset and the cycle after, mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, mem_rdata=0.
- Hit: valid[index] && tag[index]==tag.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: all outputs low.
- IDLE, request and hit:
  - mem_resp=1 in the same cycle (combinational, 0-cycle hit latency).
  - Read: mem_rdata=data[index] word[word].
  - Write: at the edge, each byte b with mem_byte_enable[b]=1 is written into word[word]; dirty<=1. Byte mask 0 still asserts mem_resp and sets dirty.
- IDLE, request and miss:
  - dirty[index]=1 -> WRITEBACK.
  - Otherwise -> ALLOCATE.
  - mem_resp=0.
- WRITEBACK: pmem_write=1, pmem_address={tag[index],index,5'b0}, pmem_wdata=data[index], all held stable. On pmem_resp: dirty<=0, next ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_address={mem_address[31:5],5'b0}. On pmem_resp: data<=pmem_rdata, tag<=tag, valid<=1, dirty<=0, next IDLE.
- After a fill, IDLE re-evaluates and hits, so mem_resp fires exactly one cycle after the fill pmem_resp.
- Miss latency: clean miss = T_mem+1 cycles; dirty miss = 2*T_mem+1 cycles.
- pmem_read and pmem_write are never both 1. At most one pmem transaction is outstanding. pmem_resp is ignored in IDLE.
- mem_read && mem_write together is illegal; the cache treats it as a write.
- The requester holds all request inputs stable until mem_resp. Changing them mid-miss is a protocol violation and behaviour is undefined.
- mem_resp is asserted for exactly one cycle per request. A new request may be presented in the cycle after mem_resp.
- Reset mid-WRITEBACK or mid-ALLOCATE: abort to IDLE and drop pmem_read/pmem_write on the next cycle. Dirty data is lost. No mem_resp is issued for the aborted request.
- mem_rdata is 0 whenever mem_resp=0 or the request is a write.

Test Plan:
- Cold read 0x0000_0104, pmem returns line with word1=0xDEADBEEF after 3 cycles -> pmem_read addr 0x0000_0100; mem_resp one cycle after pmem_resp; mem_rdata=0xDEADBEEF.
- Repeat read of 0x0000_0104 -> mem_resp same cycle; mem_rdata=0xDEADBEEF; no pmem activity.
- Write 0x0000_0104, wdata 0x1122_3344, mbe 4'b0110, then read -> read returns 0xDE22_33EF; dirty set.
- Read conflicting 0x0000_1104 (same index 0) -> pmem_write to 0x0000_0100 with word1=0xDE2233EF; then pmem_read 0x0000_1100; correct data returned.
- Clean conflict miss after fill -> only pmem_read, no pmem_write.
- Assert rst during ALLOCATE -> pmem_read=0 the next cycle, no mem_resp; re-reading 0x0000_1104 misses again (valid cleared).
